// File: rtl/custom_logic_tld.sv
// Image-filter accelerator top: streams packed 8-bit pixels from SDRAM, applies a
// per-lane filter and writes each word back to a destination buffer.

module custom_logic_tld_chk (
  input logic clk,
  input logic n_rst,
  input logic rd_en,
  input logic wr_en
);

  rw_exclusive: assert property (@(posedge clk) disable iff (n_rst) !(rd_en && wr_en));
  rd_single:    assert property (@(posedge clk) disable iff (n_rst) rd_en |=> !rd_en);
  wr_single:    assert property (@(posedge clk) disable iff (n_rst) wr_en |=> !wr_en);

endmodule

module custom_logic_tld #(
  parameter int ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        startControlRegister,
  input  logic [12:0] imageWidth,
  input  logic [12:0] imageHeight,
  input  logic [25:0] start_addr_sdram,
  input  logic [25:0] finish_addr_sdram,
  input  logic [1:0]  filterMode,
  input  logic [7:0]  betaValue,
  input  logic [31:0] data_sdram,
  input  logic        sdram_datareadvalid,
  output logic        sdram_read_en,
  output logic        sdram_write_en,
  output logic [25:0] address_sdram,
  output logic [31:0] writeData_sdram,
  output logic        finish_flag
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    PROC    = 3'd3,
    WR      = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_r;
  logic [25:0] src_base_r;
  logic [25:0] dst_base_r;
  logic [1:0]  mode_r;
  logic [7:0]  beta_r;
  logic [25:0] words_r;
  logic [25:0] idx_r;
  logic [31:0] rdata_r;
  logic        read_en_r;
  logic        write_en_r;
  logic [25:0] address_r;
  logic [31:0] wdata_r;
  logic        finish_r;

  logic [25:0] pixels_s;
  logic [25:0] words_s;
  logic [25:0] idx_next_s;
  logic [25:0] step_s;
  logic [25:0] idx_off_s;
  logic [25:0] next_off_s;

  // Max 8191*8191+3 still fits in 26 bits, so no carry is lost here.
  assign pixels_s   = {13'd0, imageWidth} * {13'd0, imageHeight};
  assign words_s    = (pixels_s + 26'd3) >> 2;
  assign idx_next_s = idx_r + 26'd1;
  assign step_s     = 26'(ADDR_STEP);
  assign idx_off_s  = idx_r * step_s;
  assign next_off_s = idx_next_s * step_s;

  function automatic logic [7:0] filter_pixel(input logic [7:0] p, input logic [1:0] mode,
                                              input logic [7:0] beta);
    logic [8:0] sum;
    sum = {1'b0, p} + {1'b0, beta};
    case (mode)
      2'b00:   filter_pixel = p;
      2'b01:   filter_pixel = sum[8] ? 8'hFF : sum[7:0];
      2'b10:   filter_pixel = 8'hFF - p;
      2'b11:   filter_pixel = (p >= beta) ? 8'hFF : 8'h00;
      default: filter_pixel = p;
    endcase
  endfunction

  function automatic logic [31:0] filter_word(input logic [31:0] w, input logic [1:0] mode,
                                              input logic [7:0] beta);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = filter_pixel(w[i*8 +: 8], mode, beta);
    end
    filter_word = r;
  endfunction

  // Job FSM; request outputs are registered and valid for exactly the state they belong to.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_r    <= IDLE;
      src_base_r <= 26'd0;
      dst_base_r <= 26'd0;
      mode_r     <= 2'd0;
      beta_r     <= 8'd0;
      words_r    <= 26'd0;
      idx_r      <= 26'd0;
      rdata_r    <= 32'd0;
      read_en_r  <= 1'b0;
      write_en_r <= 1'b0;
      address_r  <= 26'd0;
      wdata_r    <= 32'd0;
      finish_r   <= 1'b0;
    end else begin
      read_en_r  <= 1'b0;
      write_en_r <= 1'b0;
      address_r  <= 26'd0;
      wdata_r    <= 32'd0;
      finish_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (startControlRegister) begin
            src_base_r <= start_addr_sdram;
            dst_base_r <= finish_addr_sdram;
            mode_r     <= filterMode;
            beta_r     <= betaValue;
            words_r    <= words_s;
            idx_r      <= 26'd0;
            if (words_s == 26'd0) begin
              state_r  <= DONE;
              finish_r <= 1'b1;
            end else begin
              state_r   <= RD_REQ;
              read_en_r <= 1'b1;
              address_r <= start_addr_sdram;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_REQ: begin
          state_r <= RD_WAIT;
        end
        RD_WAIT: begin
          if (sdram_datareadvalid) begin
            rdata_r <= data_sdram;
            state_r <= PROC;
          end else begin
            state_r <= RD_WAIT;
          end
        end
        PROC: begin
          state_r    <= WR;
          write_en_r <= 1'b1;
          address_r  <= dst_base_r + idx_off_s;
          wdata_r    <= filter_word(rdata_r, mode_r, beta_r);
        end
        WR: begin
          idx_r <= idx_next_s;
          if (idx_next_s == words_r) begin
            state_r  <= DONE;
            finish_r <= 1'b1;
          end else begin
            state_r   <= RD_REQ;
            read_en_r <= 1'b1;
            address_r <= src_base_r + next_off_s;
          end
        end
        DONE: begin
          // Held start must not retrigger; wait for the level to drop.
          if (!startControlRegister) begin
            state_r <= IDLE;
          end else begin
            state_r  <= DONE;
            finish_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign sdram_read_en   = read_en_r;
  assign sdram_write_en  = write_en_r;
  assign address_sdram   = address_r;
  assign writeData_sdram = wdata_r;
  assign finish_flag     = finish_r;

  custom_logic_tld_chk u_chk (
    .clk   (clk),
    .n_rst (n_rst),
    .rd_en (read_en_r),
    .wr_en (write_en_r)
  );

endmodule

// File: tb/tb_custom_logic_tld.sv
// Directed self-checking bench for custom_logic_tld.

module tb_custom_logic_tld;

  logic        clk;
  logic        n_rst;
  logic        startControlRegister;
  logic [12:0] imageWidth;
  logic [12:0] imageHeight;
  logic [25:0] start_addr_sdram;
  logic [25:0] finish_addr_sdram;
  logic [1:0]  filterMode;
  logic [7:0]  betaValue;
  logic [31:0] data_sdram;
  logic        sdram_datareadvalid;
  logic        sdram_read_en;
  logic        sdram_write_en;
  logic [25:0] address_sdram;
  logic [31:0] writeData_sdram;
  logic        finish_flag;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;

  custom_logic_tld #(.ADDR_STEP(4)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .startControlRegister (startControlRegister),
    .imageWidth           (imageWidth),
    .imageHeight          (imageHeight),
    .start_addr_sdram     (start_addr_sdram),
    .finish_addr_sdram    (finish_addr_sdram),
    .filterMode           (filterMode),
    .betaValue            (betaValue),
    .data_sdram           (data_sdram),
    .sdram_datareadvalid  (sdram_datareadvalid),
    .sdram_read_en        (sdram_read_en),
    .sdram_write_en       (sdram_write_en),
    .address_sdram        (address_sdram),
    .writeData_sdram      (writeData_sdram),
    .finish_flag          (finish_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sdram_read_en === 1'b1) rd_cnt <= rd_cnt + 1;
    if (sdram_write_en === 1'b1) wr_cnt <= wr_cnt + 1;
    if (sdram_read_en === 1'b1 && sdram_write_en === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [12:0] w, input logic [12:0] h, input logic [25:0] s,
                           input logic [25:0] d, input logic [1:0] m, input logic [7:0] b);
    imageWidth = w;
    imageHeight = h;
    start_addr_sdram = s;
    finish_addr_sdram = d;
    filterMode = m;
    betaValue = b;
    startControlRegister = 1'b1;
  endtask

  task automatic end_job();
    startControlRegister = 1'b0;
    step();
    step();
  endtask

  task automatic serve_read(input logic [31:0] d, output logic ok, output logic [25:0] a);
    ok = 1'b0;
    a = 26'd0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      if (sdram_read_en === 1'b1) begin
        ok = 1'b1;
        a = address_sdram;
      end
    end
    if (ok) begin
      step();
      data_sdram = d;
      sdram_datareadvalid = 1'b1;
      step();
      sdram_datareadvalid = 1'b0;
      data_sdram = 32'd0;
    end
  endtask

  task automatic wait_write(output logic ok, output logic [25:0] a, output logic [31:0] d);
    ok = 1'b0;
    a = 26'd0;
    d = 32'd0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      if (sdram_write_en === 1'b1) begin
        ok = 1'b1;
        a = address_sdram;
        d = writeData_sdram;
      end
    end
  endtask

  task automatic run_word(input logic [1:0] m, input logic [7:0] b, input logic [31:0] din,
                          output logic ok, output logic [31:0] wd, output logic fin);
    logic okr, okw;
    logic [25:0] ra, wa;
    start_job(13'd4, 13'd1, 26'h300, 26'h400, m, b);
    serve_read(din, okr, ra);
    wait_write(okw, wa, wd);
    step();
    fin = finish_flag;
    ok = okr && okw;
    end_job();
  endtask

  task automatic test_reset();
    logic got;
    int rc, wc;
    n_rst = 1'b1;
    repeat (3) step();
    tests++;
    if ({sdram_read_en, sdram_write_en, address_sdram, writeData_sdram, finish_flag} !== 61'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0",
               {sdram_read_en, sdram_write_en, address_sdram, writeData_sdram, finish_flag});
    end
    n_rst = 1'b0;
    start_job(13'd4, 13'd1, 26'h100, 26'h200, 2'b00, 8'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = (sdram_read_en === 1'b1);
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL reset_job_read: got no read required a read");
    end
    step();
    n_rst = 1'b1;
    startControlRegister = 1'b0;
    step();
    tests++;
    if ({sdram_read_en, sdram_write_en, address_sdram, writeData_sdram, finish_flag} !== 61'd0) begin
      fails++;
      $display("FAIL reset_midjob_outputs: got %h required 0",
               {sdram_read_en, sdram_write_en, address_sdram, writeData_sdram, finish_flag});
    end
    n_rst = 1'b0;
    rc = rd_cnt;
    wc = wr_cnt;
    data_sdram = 32'hDEADBEEF;
    sdram_datareadvalid = 1'b1;
    step();
    sdram_datareadvalid = 1'b0;
    repeat (10) step();
    tests++;
    if (wr_cnt !== wc || rd_cnt !== rc || finish_flag !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_activity: got rd=%0d wr=%0d fin=%b required rd=%0d wr=%0d fin=0",
               rd_cnt, wr_cnt, finish_flag, rc, wc);
    end
  endtask

  task automatic test_passthrough();
    logic okr, okw;
    logic [25:0] ra, wa;
    logic [31:0] wd;
    int rc, wc;
    rc = rd_cnt;
    wc = wr_cnt;
    start_job(13'd4, 13'd1, 26'h100, 26'h200, 2'b00, 8'd0);
    serve_read(32'h11223344, okr, ra);
    tests++;
    if (!okr || ra !== 26'h100) begin
      fails++;
      $display("FAIL pt_read_addr: got ok=%b addr=%h required ok=1 addr=100", okr, ra);
    end
    wait_write(okw, wa, wd);
    tests++;
    if (!okw || wa !== 26'h200 || wd !== 32'h11223344) begin
      fails++;
      $display("FAIL pt_write: got ok=%b addr=%h data=%h required 1 200 11223344", okw, wa, wd);
    end
    step();
    tests++;
    if (finish_flag !== 1'b1 || rd_cnt - rc !== 1 || wr_cnt - wc !== 1) begin
      fails++;
      $display("FAIL pt_finish: got fin=%b rd=%0d wr=%0d required 1 1 1",
               finish_flag, rd_cnt - rc, wr_cnt - wc);
    end
    end_job();
  endtask

  task automatic test_brighten();
    logic okr, okw;
    logic [25:0] ra, wa;
    logic [31:0] wd;
    start_job(13'd2, 13'd2, 26'h500, 26'h600, 2'b01, 8'd20);
    serve_read(32'hF00AEC00, okr, ra);
    // configuration changes after latch must be ignored
    filterMode = 2'b10;
    betaValue = 8'd0;
    finish_addr_sdram = 26'h700;
    wait_write(okw, wa, wd);
    tests++;
    if (!okr || !okw || wa !== 26'h600 || wd !== 32'hFF1EFF14) begin
      fails++;
      $display("FAIL brighten: got ok=%b%b addr=%h data=%h required 11 600 FF1EFF14", okr, okw, wa, wd);
    end
    end_job();
  endtask

  task automatic test_threshold_invert();
    logic ok, fin;
    logic [31:0] wd;
    run_word(2'b11, 8'd128, 32'h7F80FF00, ok, wd, fin);
    tests++;
    if (!ok || !fin || wd !== 32'h00FFFF00) begin
      fails++;
      $display("FAIL threshold: got ok=%b fin=%b data=%h required 1 1 00FFFF00", ok, fin, wd);
    end
    run_word(2'b10, 8'd77, 32'h00FF1234, ok, wd, fin);
    tests++;
    if (!ok || !fin || wd !== 32'hFF00EDCB) begin
      fails++;
      $display("FAIL invert: got ok=%b fin=%b data=%h required 1 1 FF00EDCB", ok, fin, wd);
    end
  endtask

  task automatic test_3x3();
    logic okr, okw;
    logic [25:0] ra, wa;
    logic [31:0] wd;
    logic [31:0] din [3];
    logic [31:0] dexp [3];
    int rc;
    din[0] = 32'h01020304; dexp[0] = 32'hFEFDFCFB;
    din[1] = 32'hA5A5A5A5; dexp[1] = 32'h5A5A5A5A;
    din[2] = 32'h00000000; dexp[2] = 32'hFFFFFFFF;
    start_job(13'd3, 13'd3, 26'h1000, 26'h2000, 2'b10, 8'd0);
    for (int k = 0; k < 3; k++) begin
      serve_read(din[k], okr, ra);
      wait_write(okw, wa, wd);
      tests++;
      if (!okr || !okw || ra !== 26'h1000 + 26'(4 * k) || wa !== 26'h2000 + 26'(4 * k) || wd !== dexp[k]) begin
        fails++;
        $display("FAIL img3x3_word%0d: got ok=%b%b ra=%h wa=%h data=%h required ra=%h wa=%h data=%h",
                 k, okr, okw, ra, wa, wd, 26'h1000 + 26'(4 * k), 26'h2000 + 26'(4 * k), dexp[k]);
      end
    end
    rc = rd_cnt;
    repeat (5) step();
    tests++;
    if (finish_flag !== 1'b1 || rd_cnt !== rc) begin
      fails++;
      $display("FAIL img3x3_hold: got fin=%b extra_reads=%0d required fin=1 extra_reads=0",
               finish_flag, rd_cnt - rc);
    end
    startControlRegister = 1'b0;
    step();
    tests++;
    if (finish_flag !== 1'b0) begin
      fails++;
      $display("FAIL img3x3_release: got fin=%b required 0", finish_flag);
    end
    step();
  endtask

  task automatic test_zero_size();
    int rc, wc;
    rc = rd_cnt;
    wc = wr_cnt;
    start_job(13'd0, 13'd5, 26'h100, 26'h200, 2'b00, 8'd0);
    step();
    tests++;
    if (finish_flag !== 1'b1) begin
      fails++;
      $display("FAIL zero_finish: got fin=%b required 1", finish_flag);
    end
    repeat (4) step();
    tests++;
    if (finish_flag !== 1'b1 || rd_cnt !== rc || wr_cnt !== wc) begin
      fails++;
      $display("FAIL zero_no_access: got fin=%b rd=%0d wr=%0d required 1 0 0",
               finish_flag, rd_cnt - rc, wr_cnt - wc);
    end
    end_job();
  endtask

  task automatic test_delayed_valid();
    logic got;
    int bad;
    start_job(13'd4, 13'd1, 26'h40, 26'h80, 2'b00, 8'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = (sdram_read_en === 1'b1);
    end
    tests++;
    if (!got || address_sdram !== 26'h40) begin
      fails++;
      $display("FAIL delay_read: got ok=%b addr=%h required 1 40", got, address_sdram);
    end
    // a strobe during the request cycle is outside RD_WAIT and must be dropped
    data_sdram = 32'h0BADF00D;
    sdram_datareadvalid = 1'b1;
    step();
    sdram_datareadvalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (sdram_read_en !== 1'b0 || sdram_write_en !== 1'b0) bad++;
      step();
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL delay_idle_wait: got %0d active cycles required 0", bad);
    end
    data_sdram = 32'hCAFEF00D;
    sdram_datareadvalid = 1'b1;
    step();
    sdram_datareadvalid = 1'b0;
    tests++;
    if (sdram_write_en !== 1'b0) begin
      fails++;
      $display("FAIL delay_early_write: got wr=%b required 0", sdram_write_en);
    end
    step();
    tests++;
    if (sdram_write_en !== 1'b1 || address_sdram !== 26'h80 || writeData_sdram !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL delay_write: got wr=%b addr=%h data=%h required 1 80 CAFEF00D",
               sdram_write_en, address_sdram, writeData_sdram);
    end
    step();
    end_job();
  endtask

  task automatic test_wrap();
    logic okr, okw;
    logic [25:0] ra, wa;
    logic [31:0] wd;
    start_job(13'd8, 13'd1, 26'h3FFFFFC, 26'h3FFFFFC, 2'b01, 8'd1);
    serve_read(32'h000000FE, okr, ra);
    wait_write(okw, wa, wd);
    tests++;
    if (!okr || !okw || ra !== 26'h3FFFFFC || wa !== 26'h3FFFFFC || wd !== 32'h010101FF) begin
      fails++;
      $display("FAIL wrap_word0: got ra=%h wa=%h data=%h required 3FFFFFC 3FFFFFC 010101FF", ra, wa, wd);
    end
    serve_read(32'h12345678, okr, ra);
    wait_write(okw, wa, wd);
    tests++;
    if (!okr || !okw || ra !== 26'h0 || wa !== 26'h0 || wd !== 32'h13355779) begin
      fails++;
      $display("FAIL wrap_word1: got ra=%h wa=%h data=%h required 0 0 13355779", ra, wa, wd);
    end
    step();
    tests++;
    if (finish_flag !== 1'b1 || both_cnt !== 0) begin
      fails++;
      $display("FAIL wrap_finish: got fin=%b overlap=%0d required 1 0", finish_flag, both_cnt);
    end
    end_job();
  endtask

  initial begin
    n_rst = 1'b1;
    startControlRegister = 1'b0;
    imageWidth = 13'd0;
    imageHeight = 13'd0;
    start_addr_sdram = 26'd0;
    finish_addr_sdram = 26'd0;
    filterMode = 2'd0;
    betaValue = 8'd0;
    data_sdram = 32'd0;
    sdram_datareadvalid = 1'b0;
    test_reset();
    test_passthrough();
    test_brighten();
    test_threshold_invert();
    test_3x3();
    test_zero_size();
    test_delayed_valid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/custom_logic_tld.md
Name: custom_logic_tld

Overview:
Top level of the custom image-filter accelerator. When started, it streams an image stored in SDRAM as packed 8-bit pixels, four per 32-bit word. Each word is read, a per-pixel filter selected by filterMode is applied, and the result is written to a destination buffer in SDRAM. It sits between the control/status register block (start, geometry, addresses, mode, beta) and the SDRAM controller's master read/write interface.

Parameters:
ADDR_STEP, 4, address increment per 32-bit word (SDRAM addresses are byte addresses).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
n_rst  input  1  synchronous reset, ACTIVE-HIGH despite its name; sampled on the rising edge of clk.
startControlRegister  input  1  level start request from the control register.
imageWidth  input  13  image width in pixels.
imageHeight  input  13  image height in pixels.
start_addr_sdram  input  26  byte address of the source image's first word.
finish_addr_sdram  input  26  byte address of the destination buffer's first word (may equal start_addr_sdram for in-place operation).
filterMode  input  2  filter select.
betaValue  input  8  filter constant.
data_sdram  input  32  read data from SDRAM.
sdram_datareadvalid  input  1  read data valid strobe.
sdram_read_en  output  1  one-cycle read request.
sdram_write_en  output  1  one-cycle write request.
address_sdram  output  26  address for the current read or write.
writeData_sdram  output  32  write data.
finish_flag  output  1  job complete.

Behaviour:
- Reset (n_rst=1 at a clk rising edge): state goes to IDLE; every output is 0; internal counters and registers are cleared. Reset mid-job aborts the job immediately, and no further read or write is issued.
- Job latch (IDLE with startControlRegister=1): latch width, height, both addresses, mode and beta, then compute:
  - pixels = width*height (26-bit);
  - words = (pixels+3)>>2.
  - If words==0, go to DONE directly; otherwise go to RD_REQ.
- Later changes to the configuration inputs do not affect a running job.
- States and transitions:
  - IDLE: wait for start, as above.
  - RD_REQ: sdram_read_en=1 for exactly one cycle; address_sdram = src_base + idx*ADDR_STEP. Go to RD_WAIT.
  - RD_WAIT: all request outputs 0. Wait for sdram_datareadvalid=1, capture data_sdram, go to PROC. Wait time is unbounded; readvalid seen outside RD_WAIT is ignored.
  - PROC: one cycle; register the filtered word.
  - WR: sdram_write_en=1 for exactly one cycle; address_sdram = dst_base + idx*ADDR_STEP; writeData_sdram = filtered word. Increment idx. If idx (after increment) == words, go to DONE; otherwise go to RD_REQ.
  - DONE: finish_flag=1, held. Return to IDLE when startControlRegister=0; finish_flag drops on that transition. A start held high does not retrigger.
- Read and write enables are never asserted in the same cycle. Exactly one read and one write are issued per word, in order.
- Filter: applied independently to each byte lane [7:0], [15:8], [23:16], [31:24]. With p = pixel and b = betaValue:
  - 00: pass-through, out = p.
  - 01: brighten, out = min(p+b, 255) (9-bit add, saturate).
  - 10: invert, out = 255-p.
  - 11: threshold, out = (p>=b) ? 255 : 0.
- Address arithmetic is modulo 2^26 (wraps silently).
- When the pixel count is not a multiple of 4, the last word is still processed whole; the padding lanes are filtered like the others.
- Minimum per-word cost is 4 cycles plus the read latency.

Test Plan:
- Reset: assert n_rst=1 mid-job (during RD_WAIT) -> next cycle all outputs 0 and state IDLE; no write occurs after reset.
- Pass-through 4x1 image: start=0x100, finish=0x200, mode 00, read returns 0x11223344 -> one read at 0x100, one write at 0x200 of 0x11223344, then finish_flag=1.
- Brighten with beta=20, word 0xF0_0A_EC_00 -> written 0xFF_1E_FF_14.
- Threshold with beta=128, word 0x7F_80_FF_00 -> 0x00_FF_FF_00. Invert on 0x00FF1234 -> 0xFF00EDCB.
- 3x3 image (9 pixels) -> 3 reads and 3 writes at src/dst +0, +4, +8. finish_flag stays high until start drops, then returns to 0.
- Width=0, start=1 -> finish_flag=1 with no read or write asserted. Delaying readvalid 10 cycles -> read_en stays low while waiting; write occurs 2 cycles after readvalid.
